forwarding_control_unit: RTL and testbench

- Producer side of the Register_Bank_Block operand-select interface; it drives mux_sel_A, mux_sel_B, imm_sel and RW_dm.
- Tracks destination registers of in-flight instructions through the OF, EX, DM and WB stages, and compares them with the source registers of the instruction entering OF.
- Selects the register file or a forwarded result (ans_ex, ans_dm, ans_wb) for each operand.
- Detects load-use hazards and inserts one bubble.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fwd_match.sv | 16 +
 rtl/forwarding_control_unit.sv | 57 +++++
 tb/tb_forwarding_control_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: forwarding select codes, pipeline stage entry type and the forwarding match rule.
package mips_pkg;
    localparam int REG_AW     = 5;
    localparam int NSTAGE_FWD = 3;
    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_DM  = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;
    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic              is_load;
        logic [REG_AW-1:0] dest;
    } stage_t;
    function automatic logic fwd_hit(stage_t s, logic [REG_AW-1:0] r);
        return s.valid & s.wr_en & (s.dest == r) & (r != '0);
    endfunction
endpackage

// File: rtl/fwd_match.sv
// fwd_match: picks the youngest in-flight writer of src among EX, DM and WB.
module fwd_match
    import mips_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  stage_t            ex,
    input  stage_t            dm,
    input  stage_t            wb,
    output logic [1:0]        sel
);
    logic unused_load;
    assign unused_load = ex.is_load ^ dm.is_load ^ wb.is_load;
    assign sel = fwd_hit(ex, src) ? SEL_EX :
                 fwd_hit(dm, src) ? SEL_DM :
                 fwd_hit(wb, src) ? SEL_WB : SEL_REG;
endmodule

// File: rtl/forwarding_control_unit.sv
// forwarding_control_unit: registered operand selects, load-use bubble insertion and write-back address.
module forwarding_control_unit #(
    parameter int REG_AW     = 5,
    parameter int NSTAGE_FWD = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               id_valid,
    input  logic [REG_AW-1:0]                  RA_id,
    input  logic [REG_AW-1:0]                  RB_id,
    input  logic [REG_AW-1:0]                  RW_id,
    input  logic                               wr_en_id,
    input  logic                               is_load_id,
    input  logic                               imm_sel_id,
    input  logic                               stall,
    input  logic                               flush,
    output logic [$clog2(NSTAGE_FWD+1)-1:0]    mux_sel_A,
    output logic [$clog2(NSTAGE_FWD+1)-1:0]    mux_sel_B,
    output logic                               imm_sel,
    output logic [REG_AW-1:0]                  RW_dm,
    output logic                               wr_dm,
    output logic                               hazard_stall
);
    import mips_pkg::*;
    // The WB entry is never read after the shift (it becomes old DM), so only OF/EX/DM are stored.
    stage_t of_s, ex_s, dm_s, id_s;
    logic [1:0] sel_a, sel_b;
    logic hz;
    assign hz = id_valid & of_s.valid & of_s.is_load & of_s.wr_en & (of_s.dest != '0) &
                ((RA_id == of_s.dest) | (~imm_sel_id & (RB_id == of_s.dest)));
    assign hazard_stall = hz & ~flush;
    assign id_s = '{valid: id_valid & ~flush & ~hz, wr_en: wr_en_id, is_load: is_load_id, dest: RW_id};
    // Selects are judged against the post-shift pipeline: EX = old OF, DM = old EX, WB = old DM.
    fwd_match u_match_a (.src(RA_id), .ex(of_s), .dm(ex_s), .wb(dm_s), .sel(sel_a));
    fwd_match u_match_b (.src(RB_id), .ex(of_s), .dm(ex_s), .wb(dm_s), .sel(sel_b));
    always_ff @(posedge clk) begin
        if (reset) begin
            of_s      <= '0;
            ex_s      <= '0;
            dm_s      <= '0;
            mux_sel_A <= SEL_REG;
            mux_sel_B <= SEL_REG;
            imm_sel   <= 1'b0;
            RW_dm     <= '0;
            wr_dm     <= 1'b0;
        end else if (!stall) begin
            of_s      <= id_s;
            ex_s      <= of_s;
            dm_s      <= ex_s;
            mux_sel_A <= sel_a;
            mux_sel_B <= imm_sel_id ? SEL_REG : sel_b;
            imm_sel   <= imm_sel_id;
            RW_dm     <= ex_s.dest;
            wr_dm     <= ex_s.valid & ex_s.wr_en;
        end
    end
endmodule

// File: tb/tb_forwarding_control_unit.sv
// tb_forwarding_control_unit: directed and random checks against an issue-history reference model.
module tb_forwarding_control_unit;
    logic clk = 1'b0;
    logic reset, id_valid, wr_en_id, is_load_id, imm_sel_id, stall, flush;
    logic [4:0] RA_id, RB_id, RW_id, RW_dm;
    logic [1:0] mux_sel_A, mux_sel_B;
    logic imm_sel, wr_dm, hazard_stall;
    always #5 clk = ~clk;

    forwarding_control_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .RA_id(RA_id), .RB_id(RB_id),
        .RW_id(RW_id), .wr_en_id(wr_en_id), .is_load_id(is_load_id), .imm_sel_id(imm_sel_id),
        .stall(stall), .flush(flush), .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
        .imm_sel(imm_sel), .RW_dm(RW_dm), .wr_dm(wr_dm), .hazard_stall(hazard_stall)
    );

    typedef struct {bit v; bit w; bit l; int d;} ent_t;
    ent_t hist[3];
    logic [1:0] e_a, e_b;
    logic [4:0] e_rw;
    logic e_imm, e_wr, obs_hz;
    bit known = 0, last_hz = 0;
    int total = 0, bad = 0;

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] youngest(int r);
        for (int k = 0; k < 3; k++)
            if (r != 0 && hist[k].v && hist[k].w && hist[k].d == r) return 2'(k + 1);
        return 2'd0;
    endfunction

    task automatic set_id(bit v, int ra, int rb, int rw, bit we, bit ld, bit im);
        id_valid = v; RA_id = 5'(ra); RB_id = 5'(rb); RW_id = 5'(rw);
        wr_en_id = we; is_load_id = ld; imm_sel_id = im;
    endtask

    task automatic step();
        bit hz;
        @(negedge clk);
        hz = id_valid && !flush && hist[0].v && hist[0].l && hist[0].w && hist[0].d != 0 &&
             (RA_id == hist[0].d || (!imm_sel_id && RB_id == hist[0].d));
        obs_hz = hazard_stall;
        if (known) chk("hazard_stall", obs_hz, hz);
        @(posedge clk);
        if (reset) begin
            foreach (hist[k]) hist[k] = '{0, 0, 0, 0};
            e_a = 0; e_b = 0; e_imm = 0; e_rw = 0; e_wr = 0; known = 1;
        end else if (!stall) begin
            e_a = youngest(RA_id);
            e_b = imm_sel_id ? 2'd0 : youngest(RB_id);
            e_imm = imm_sel_id;
            e_rw = 5'(hist[1].d);
            e_wr = hist[1].v && hist[1].w;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{id_valid && !flush && !hz, wr_en_id, is_load_id, int'(RW_id)};
        end
        last_hz = hz && !stall;
        #1;
        if (known) begin
            chk("mux_sel_A", mux_sel_A, e_a);
            chk("mux_sel_B", mux_sel_B, e_b);
            chk("imm_sel", imm_sel, e_imm);
            chk("wr_dm", wr_dm, e_wr);
            if (e_wr) chk("RW_dm", RW_dm, e_rw);
        end
    endtask

    task automatic ins(bit v, int ra, int rb, int rw, bit we, bit ld, bit im);
        set_id(v, ra, rb, rw, we, ld, im);
        step();
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0;
        set_id(1, 5, 5, 5, 1, 0, 0);
        step(); step();
        chk("rst_sel_A", mux_sel_A, 0); chk("rst_sel_B", mux_sel_B, 0);
        chk("rst_imm", imm_sel, 0); chk("rst_wr_dm", wr_dm, 0); chk("rst_rw_dm", RW_dm, 0);
        reset = 0;
        ins(1, 0, 0, 5, 1, 0, 0); chk("rst_hz", obs_hz, 0);
        ins(1, 5, 0, 0, 0, 0, 0); chk("chain_ex", mux_sel_A, 1);
        ins(1, 5, 0, 0, 0, 0, 0); chk("chain_dm", mux_sel_A, 2);
        ins(1, 5, 0, 0, 0, 0, 0); chk("chain_wb", mux_sel_A, 3);
        ins(1, 5, 0, 0, 0, 0, 0); chk("chain_rf", mux_sel_A, 0);
        ins(1, 0, 0, 7, 1, 0, 0); ins(1, 0, 0, 7, 1, 0, 0);
        ins(1, 0, 7, 0, 0, 0, 0); chk("prio_b", mux_sel_B, 1);
        ins(1, 0, 0, 7, 1, 0, 0); ins(1, 0, 0, 7, 1, 0, 0);
        ins(1, 0, 7, 0, 0, 0, 1); chk("imm_b", mux_sel_B, 0); chk("imm_sel", imm_sel, 1);
        ins(1, 0, 0, 6, 1, 1, 0);
        ins(1, 6, 0, 0, 0, 0, 0); chk("lu_hz", obs_hz, 1);
        step(); chk("lu_hz_clear", obs_hz, 0); chk("lu_sel", mux_sel_A, 2);
        ins(1, 0, 0, 0, 1, 0, 0); ins(1, 0, 0, 0, 0, 0, 0); chk("r0_sel", mux_sel_A, 0);
        flush = 1; ins(1, 0, 0, 3, 1, 0, 0); flush = 0;
        ins(1, 3, 3, 0, 0, 0, 0); chk("flush_a", mux_sel_A, 0); chk("flush_b", mux_sel_B, 0);
        for (int i = 0; i < 4; i++) begin
            ins(0, 0, 0, 0, 0, 0, 0);
            chk("flush_wb", 8'(wr_dm && RW_dm == 3), 0);
        end
        ins(1, 0, 0, 5, 1, 0, 0);
        ins(1, 5, 0, 0, 0, 0, 0); chk("st_pre", mux_sel_A, 1);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("st_frozen", mux_sel_A, 1);
        end
        stall = 0;
        step(); chk("st_dm", mux_sel_A, 2);
        step(); chk("st_wb", mux_sel_A, 3);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(99) == 0);
            stall = ($urandom_range(9) == 0);
            flush = ($urandom_range(11) == 0);
            if (!last_hz) set_id($urandom_range(4) != 0, $urandom_range(3), $urandom_range(3),
                                 $urandom_range(3), $urandom_range(1), $urandom_range(2) == 0,
                                 $urandom_range(3) == 0);
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
